// File: rtl/data_memory_access.sv
// MIPS memory stage: checks the ALU byte address for LW/SW, runs a req/ack
// transaction on the data-memory bus and stalls the core until it completes.
module data_memory_access #(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter logic [31:0] MEM_BASE       = 32'h1001_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [31:0]           address_i,
    input  logic [31:0]           write_data_i,
    output logic                  stall_o,
    output logic [31:0]           read_data_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [31:0]           bus_wdata_o,
    input  logic                  bus_ack_i,
    input  logic [31:0]           bus_rdata_i
);

    localparam int unsigned   CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TERM  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [32:0]   LIMIT = 33'(1) << (ADDR_WIDTH + 2);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [31:0]   offset;
    logic          fault;

    // Addresses below MEM_BASE wrap to huge offsets and fail the range check.
    always_comb begin
        offset = address_i - MEM_BASE;
        fault  = (mem_read_i & mem_write_i)
               | (address_i[1:0] != 2'b00)
               | ({1'b0, offset} >= LIMIT);
    end

    always_comb begin
        stall_o = 1'b0;
        case (state)
            IDLE:    stall_o = mem_read_i | mem_write_i;
            REQ:     stall_o = 1'b1;
            default: stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            count       <= '0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            read_data_o <= '0;
            done_o      <= 1'b0;
            error_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_read_i | mem_write_i) begin
                        if (fault) begin
                            error_o <= 1'b1;
                            done_o  <= 1'b1;
                            state   <= DONE;
                        end else begin
                            bus_addr_o  <= offset[ADDR_WIDTH+1:2];
                            bus_we_o    <= mem_write_i;
                            bus_wdata_o <= write_data_i;
                            error_o     <= 1'b0;
                            count       <= '0;
                            bus_req_o   <= 1'b1;
                            state       <= REQ;
                        end
                    end
                end
                REQ: begin
                    // An ack arriving on the terminal count still completes cleanly.
                    if (bus_ack_i) begin
                        bus_req_o <= 1'b0;
                        if (!bus_we_o) begin
                            read_data_o <= bus_rdata_i;
                        end
                        done_o <= 1'b1;
                        state  <= DONE;
                    end else if (count == TERM) begin
                        bus_req_o <= 1'b0;
                        error_o   <= 1'b1;
                        done_o    <= 1'b1;
                        state     <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_access.sv
// Self-checking bench for data_memory_access: directed cases followed by
// randomized accesses, compared against an address/latency reference model.
module tb_data_memory_access;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int unsigned AW    = 10;
    localparam int unsigned TO    = 4;
    localparam int unsigned WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_read, mem_write;
    logic [31:0]   address, write_data;
    logic          stall;
    logic [31:0]   read_data;
    logic          done, error;
    logic          bus_req, bus_we;
    logic [AW-1:0] bus_addr;
    logic [31:0]   bus_wdata;
    logic          bus_ack;
    logic [31:0]   bus_rdata;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    logic [31:0] exp_rdata;
    logic        exp_err;

    always #5 clk = ~clk;

    data_memory_access #(
        .ADDR_WIDTH    (AW),
        .MEM_BASE      (BASE),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_read_i  (mem_read),
        .mem_write_i (mem_write),
        .address_i   (address),
        .write_data_i(write_data),
        .stall_o     (stall),
        .read_data_o (read_data),
        .done_o      (done),
        .error_o     (error),
        .bus_req_o   (bus_req),
        .bus_we_o    (bus_we),
        .bus_addr_o  (bus_addr),
        .bus_wdata_o (bus_wdata),
        .bus_ack_i   (bus_ack),
        .bus_rdata_i (bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete LW/SW; w = REQ cycle index carrying the ack (w >= TO means no ack).
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int unsigned w);
        logic [31:0] off;
        logic [31:0] rval;
        logic        fault;
        off   = addr - BASE;
        fault = (rd && wr) || (addr % 4 != 0) || (off >= 4 * WORDS);
        rval  = '0;

        mem_read   = rd;
        mem_write  = wr;
        address    = addr;
        write_data = wdata;
        bus_ack    = 1'($urandom);
        bus_rdata  = $urandom;
        #1;
        chk("idle_stall", 32'(stall), 32'(rd | wr));
        chk("idle_done", 32'(done), 32'd0);
        step();
        bus_ack = 1'b0;

        if (fault) begin
            exp_err = 1'b1;
            chk("fault_no_req", 32'(bus_req), 32'd0);
        end else begin
            for (int n = 0; n < int'(TO); n++) begin
                chk("req", 32'(bus_req), 32'd1);
                chk("req_stall", 32'(stall), 32'd1);
                chk("req_we", 32'(bus_we), 32'(wr));
                chk("req_addr", 32'(bus_addr), off / 4);
                chk("req_wdata", bus_wdata, wdata);
                chk("req_done", 32'(done), 32'd0);
                if (n == int'(w)) begin
                    rval      = $urandom;
                    bus_ack   = 1'b1;
                    bus_rdata = rval;
                end
                step();
                bus_ack   = 1'b0;
                bus_rdata = $urandom;
                if (n == int'(w)) break;
            end
            if (w < TO) begin
                exp_err = 1'b0;
                if (rd) exp_rdata = rval;
            end else begin
                exp_err = 1'b1;
            end
        end

        chk("done_pulse", 32'(done), 32'd1);
        chk("done_error", 32'(error), 32'(exp_err));
        chk("done_rdata", read_data, exp_rdata);
        chk("done_req", 32'(bus_req), 32'd0);
        chk("done_stall", 32'(stall), 32'd0);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        bus_ack   = 1'($urandom);
        step();
        bus_ack = 1'b0;
        chk("after_done", 32'(done), 32'd0);
        chk("after_stall", 32'(stall), 32'd0);
        chk("after_error", 32'(error), 32'(exp_err));
        chk("after_rdata", read_data, exp_rdata);
    endtask

    initial begin
        logic        rd, wr;
        logic [31:0] addr;
        int unsigned sel;

        reset      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        address    = '0;
        write_data = '0;
        bus_ack    = 1'b0;
        bus_rdata  = '0;
        exp_rdata  = '0;
        exp_err    = 1'b0;
        step();
        step();
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_we", 32'(bus_we), 32'd0);
        chk("rst_addr", 32'(bus_addr), 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_rdata", read_data, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        reset = 1'b1;
        step();

        // Directed cases
        access(1'b1, 1'b0, 32'h1001_0008, 32'h0, 0);
        access(1'b0, 1'b1, 32'h1001_0FFC, 32'h1234_5678, 3);
        access(1'b1, 1'b0, 32'h1001_0006, 32'h0, 0);
        access(1'b1, 1'b0, 32'h1001_1000, 32'h0, 0);
        access(1'b0, 1'b1, 32'h0FFF_FFFC, 32'hAAAA_5555, 0);
        access(1'b1, 1'b1, 32'h1001_0010, 32'h0, 0);
        access(1'b1, 1'b0, 32'h1001_0000, 32'h0, 1);
        access(1'b1, 1'b0, 32'h1001_0020, 32'h0, TO);
        access(1'b1, 1'b0, 32'h1001_0024, 32'h0, TO - 1);

        // Reset during the second wait cycle aborts without a done pulse
        mem_read = 1'b1;
        address  = 32'h1001_0040;
        step();
        chk("rst_mid_req0", 32'(bus_req), 32'd1);
        step();
        chk("rst_mid_req1", 32'(bus_req), 32'd1);
        reset    = 1'b0;
        mem_read = 1'b0;
        step();
        reset     = 1'b1;
        exp_rdata = '0;
        exp_err   = 1'b0;
        chk("rst_mid_busreq", 32'(bus_req), 32'd0);
        chk("rst_mid_stall", 32'(stall), 32'd0);
        chk("rst_mid_rdata", read_data, 32'd0);
        chk("rst_mid_error", 32'(error), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        step();
        chk("rst_mid_done2", 32'(done), 32'd0);
        access(1'b1, 1'b0, 32'h1001_0044, 32'h0, 0);

        // Randomized accesses
        for (int i = 0; i < 60; i++) begin
            sel  = $urandom_range(0, 9);
            rd   = 1'($urandom);
            wr   = ~rd;
            addr = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
            if (sel == 7) addr[1:0] = 2'($urandom_range(1, 3));
            if (sel == 8) addr = BASE + 32'(4 * WORDS) + 32'(4 * $urandom_range(0, 64));
            if (sel == 9) addr = BASE - 32'(4 * $urandom_range(1, 64));
            if (sel == 6) begin
                rd = 1'b1;
                wr = 1'b1;
            end
            access(rd, wr, addr, $urandom, $urandom_range(0, TO + 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_memory_access.md
Name: data_memory_access

Overview:
Memory stage directly downstream of the ALU in the MIPS datapath. It takes the ALU result as a byte address for LW/SW, checks it, and runs a req/ack transaction on the data-memory bus. It returns load data for write-back and holds the single-cycle core with a stall until the access finishes.

Parameters:
ADDR_WIDTH, 10, word-index width of the data-memory bus (memory holds 2^ADDR_WIDTH words)
MEM_BASE, 32'h1001_0000, byte address of data-memory word 0
TIMEOUT_CYCLES, 255, maximum cycles in REQ without bus_ack_i before the access is aborted

Ports:
clk  input  1  core clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset
mem_read_i  input  1  LW in flight (from control unit, level)
mem_write_i  input  1  SW in flight (from control unit, level)
address_i  input  32  byte address, ALU alu_data_o
write_data_i  input  32  store data (rt register value)
stall_o  output  1  hold PC and register-file write while high
read_data_o  output  32  last successfully loaded word
done_o  output  1  one-cycle pulse: access finished (ok or error)
error_o  output  1  last access faulted (misaligned, out of range, both strobes, timeout)
bus_req_o  output  1  bus request
bus_we_o  output  1  1 = write, 0 = read
bus_addr_o  output  ADDR_WIDTH  word index = (address_i - MEM_BASE) >> 2
bus_wdata_o  output  32  store data to memory
bus_ack_i  input  1  memory completed the request (one cycle)
bus_rdata_i  input  32  read data, valid when bus_ack_i=1

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; bus_req_o, bus_we_o, done_o, error_o = 0; bus_addr_o, bus_wdata_o, read_data_o, timeout counter = 0. Reset mid-transaction aborts the access: bus_req_o is low from the next cycle, and no done_o pulse occurs.
- States: IDLE, REQ, DONE.
- IDLE:
  - stall_o = mem_read_i | mem_write_i (combinational), so the core never advances in the cycle an access is first seen.
  - A fault is any of: both strobes high; address_i[1:0] != 0; (address_i - MEM_BASE), unsigned 32-bit, >= 4*2^ADDR_WIDTH. Addresses below MEM_BASE wrap to large values and count as out of range.
  - On a fault: go to DONE with error flag set. No bus traffic.
  - Otherwise: latch bus_addr_o, bus_we_o = mem_write_i, and bus_wdata_o; clear error_o and the timeout counter; set bus_req_o = 1; go to REQ.
- REQ:
  - stall_o = 1. bus_req_o, bus_we_o, bus_addr_o and bus_wdata_o stay stable until the access ends.
  - On bus_ack_i: bus_req_o = 0; for a read, read_data_o <= bus_rdata_i; go to DONE.
  - Without ack: the counter increments each cycle. When it equals TIMEOUT_CYCLES - 1 and no ack is present, drop bus_req_o, set error, and go to DONE.
  - If ack and the timeout expire in the same cycle, the ack wins and there is no error.
- DONE:
  - stall_o = 0; done_o = 1 for exactly this cycle; error_o is registered and valid.
  - The core retires the instruction at this edge. The next state is IDLE unconditionally, even if the strobes are still high.
- bus_ack_i in IDLE or DONE is ignored.
- read_data_o changes only on a successful read. Writes and faults leave it unchanged.
- error_o stays valid until the next accepted (non-fault) access starts.
- Latency:
  - Zero-wait access: 3 cycles (IDLE detect, REQ with ack, DONE).
  - Each wait cycle adds 1.
  - Fault: 2 cycles.
  - Timeout: 2 + TIMEOUT_CYCLES cycles.
- Non-memory instructions (both strobes low): stall_o = 0, FSM stays in IDLE, zero added latency.
- Counter width is $clog2(TIMEOUT_CYCLES+1). It does not wrap, because exit occurs at terminal count.

Test Plan:
- Zero-wait load: mem_read_i=1, address_i=32'h1001_0008, bus_ack_i=1 with bus_rdata_i=32'hDEAD_BEEF in the first REQ cycle -> bus_addr_o=2, bus_we_o=0, stall_o high 2 cycles, done_o pulse in cycle 3, read_data_o=32'hDEAD_BEEF, error_o=0.
- Store with 3 wait cycles: mem_write_i=1, address_i=32'h1001_0FFC, write_data_i=32'h1234_5678 -> bus_addr_o=1023, bus_we_o=1; addr, data and req held stable for 4 cycles until ack; read_data_o unchanged; done_o after ack.
- Faults:
  - address_i=32'h1001_0006 -> no bus_req_o, done_o on cycle 2, error_o=1.
  - Repeat with address_i=32'h1001_1000 (out of range), with 32'h0FFF_FFFC (below base), and with both strobes high -> same response each time.
- Timeout: TIMEOUT_CYCLES=4, no ack -> bus_req_o high exactly 4 cycles, then done_o with error_o=1.
- Timeout race: TIMEOUT_CYCLES=4 with ack in the 4th REQ cycle -> error_o=0 and read data captured.
- Reset mid-REQ: reset=0 during the 2nd wait cycle -> next cycle bus_req_o=0, stall_o=0, read_data_o=0, error_o=0, no done_o. A following load completes normally.
